// File: rtl/pipe_frame_pkg.sv
// Shared types and constants for the pipe byte-frame receiver.
// Optional trailing checksum byte is enabled by defining CHECKSUM_EN.
`timescale 1ns/1ps
package pipe_frame_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    PAYLOAD,
    CSUM
  } state_t;

  // Lane counter needs at least one bit even when a word is a single byte.
  function automatic int lane_w(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/pipe_frame_rx_if.sv
// Byte-stream input and word-wide write port of the frame receiver.
`timescale 1ns/1ps
interface pipe_frame_rx_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 16
);
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic [W_DATA-1:0] o_word;
  logic [W_ADDR-1:0] o_addr;
  logic              o_word_valid;
  logic              i_word_ready;
  logic              o_last;
  logic              o_frame_done;
  logic              o_sync_err;
  logic              o_csum_err;

  // The receiver sits on the slave side; the byte source / word sink is the master.
  modport slave (
    input  i_byte, i_byte_valid, i_word_ready,
    output o_byte_ready, o_word, o_addr, o_word_valid, o_last,
           o_frame_done, o_sync_err, o_csum_err
  );

  modport master (
    output i_byte, i_byte_valid, i_word_ready,
    input  o_byte_ready, o_word, o_addr, o_word_valid, o_last,
           o_frame_done, o_sync_err, o_csum_err
  );
endinterface

// File: rtl/pipe_frame_csum.sv
// 8-bit running frame sum; zero flag tells whether adding din would close the sum to 0.
`timescale 1ns/1ps
module pipe_frame_csum (
  input  logic       i_clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       acc,
  input  logic [7:0] din,
  output logic       zero
);

  logic [7:0] sum;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn)  sum <= 8'h00;
    else if (clr) sum <= 8'h00;
    else if (acc) sum <= 8'(sum + din);
  end

  assign zero = (8'(sum + din) == 8'h00);

endmodule

// File: rtl/pipe_frame_rx.sv
// Byte-frame receiver: sync hunt, address/length header, payload packed into words.
// Define CHECKSUM_EN to expect and verify a trailing checksum byte per frame.
`timescale 1ns/1ps
module pipe_frame_rx
  import pipe_frame_pkg::*;
#(
  parameter int          W_DATA    = 32,
  parameter int          W_ADDR    = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input logic           i_clk,
  input logic           resetn,
  pipe_frame_rx_if.slave bus
);

  localparam int BPW    = W_DATA / BYTE_W;
  localparam int LANE_W = lane_w(BPW);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

`ifdef CHECKSUM_EN
  localparam state_t TAIL_ST   = CSUM;
  localparam bit     TAIL_DONE = 1'b0;
`else
  localparam state_t TAIL_ST   = IDLE;
  localparam bit     TAIL_DONE = 1'b1;
`endif

  state_t              state, state_nx;
  logic [W_ADDR-1:0]   addr_q, addr_out_q;
  logic [7:0]          words_left;
  logic [LANE_W-1:0]   lane;
  logic [W_DATA-1:0]   acc_q, acc_nx, word_q;
  logic                word_valid_q, last_q, done_q, sync_err_q;
  logic                accept, load_word, last_word, frame_end, hunt_miss;

  // Byte input stalls only while a finished word is blocked downstream.
  assign bus.o_byte_ready = !(word_valid_q && !bus.i_word_ready);
  assign accept           = bus.i_byte_valid && bus.o_byte_ready;
  assign last_word        = (words_left == 8'd1);

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

`ifdef CHECKSUM_EN
  logic csum_chk, csum_zero, csum_err_q;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx  = state;
    load_word = 1'b0;
    frame_end = 1'b0;
    hunt_miss = 1'b0;
`ifdef CHECKSUM_EN
    csum_chk  = 1'b0;
`endif
    if (accept) begin
      case (state)
        IDLE: begin
          if (bus.i_byte == SYNC_BYTE) state_nx  = ADDR_HI;
          else                         hunt_miss = 1'b1;
        end
        ADDR_HI: state_nx = ADDR_LO;
        ADDR_LO: state_nx = LEN;
        LEN: begin
          if (bus.i_byte == 8'd0) begin
            state_nx  = TAIL_ST;
            frame_end = TAIL_DONE;
          end else begin
            state_nx  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (lane == LAST_LANE) begin
            load_word = 1'b1;
            if (last_word) begin
              state_nx  = TAIL_ST;
              frame_end = TAIL_DONE;
            end
          end
        end
`ifdef CHECKSUM_EN
        CSUM: begin
          state_nx  = IDLE;
          frame_end = 1'b1;
          csum_chk  = 1'b1;
        end
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_nx = acc_q;
    acc_nx[int'(lane)*BYTE_W +: BYTE_W] = bus.i_byte;
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= '0;
      addr_out_q   <= '0;
      words_left   <= '0;
      lane         <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      done_q     <= frame_end;
      sync_err_q <= hunt_miss;
      if (word_valid_q && bus.i_word_ready) word_valid_q <= 1'b0;
      if (accept) begin
        case (state)
          ADDR_HI: addr_q[15:8] <= bus.i_byte;
          ADDR_LO: addr_q[7:0]  <= bus.i_byte;
          LEN: begin
            words_left <= bus.i_byte;
            lane       <= '0;
          end
          PAYLOAD: begin
            acc_q <= acc_nx;
            lane  <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
          end
          default: ;
        endcase
      end
      // A drain and a new load in the same cycle leave valid set with the new word.
      if (load_word) begin
        word_q       <= acc_nx;
        addr_out_q   <= addr_q;
        last_q       <= last_word;
        word_valid_q <= 1'b1;
        addr_q       <= addr_q + 1'b1;
        words_left   <= words_left - 8'd1;
      end
    end
  end

`ifdef CHECKSUM_EN
  pipe_frame_csum u_csum (
    .i_clk  (i_clk),
    .resetn (resetn),
    .clr    (accept && (state == IDLE)),
    .acc    (accept && (state != IDLE)),
    .din    (bus.i_byte),
    .zero   (csum_zero)
  );

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) csum_err_q <= 1'b0;
    else         csum_err_q <= csum_chk && !csum_zero;
  end

  assign bus.o_csum_err = csum_err_q;
`else
  assign bus.o_csum_err = 1'b0;
`endif

  assign bus.o_word       = word_q;
  assign bus.o_addr       = addr_out_q;
  assign bus.o_word_valid = word_valid_q;
  assign bus.o_last       = last_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_sync_err   = sync_err_q;

endmodule

// File: tb/tb_pipe_frame_rx.sv
// Bench for pipe_frame_rx: directed and random byte streams against a frame-parsing model.
// Build with CHECKSUM_EN defined to exercise the trailing checksum byte.
`timescale 1ns/1ps
module tb_pipe_frame_rx;
  import pipe_frame_pkg::*;

  localparam int W_DATA = 32;
  localparam int BPW    = W_DATA / 8;

  typedef struct packed {
    logic [W_DATA-1:0] word;
    logic [15:0]       addr;
    logic              last;
  } wrec_t;

  logic i_clk  = 1'b0;
  logic resetn = 1'b0;

  pipe_frame_rx_if #(.W_DATA(W_DATA), .W_ADDR(16)) bus ();

  pipe_frame_rx #(.W_DATA(W_DATA), .W_ADDR(16), .SYNC_BYTE(8'hA5)) dut (
    .i_clk  (i_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  int gap_max    = 0;

  logic [7:0] stim[$];
  wrec_t      exp_q[$];
  int         exp_sync, exp_done, exp_csum;
  wrec_t      obs_q[$];
  int         obs_sync = 0, obs_done = 0, obs_csum = 0;
  int         b_words, b_sync, b_done, b_csum;

  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       bus.i_word_ready = 1'b1;
      1:       bus.i_word_ready = ($urandom_range(0, 3) != 0);
      default: bus.i_word_ready = 1'b0;
    endcase
  end

  always @(negedge i_clk) begin
    if (resetn) begin
      if (bus.o_word_valid && bus.i_word_ready)
        obs_q.push_back({bus.o_word, bus.o_addr, bus.o_last});
      if (bus.o_sync_err)   obs_sync++;
      if (bus.o_frame_done) obs_done++;
      if (bus.o_csum_err)   obs_csum++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    forever begin
      @(negedge i_clk);
      if (bus.o_byte_ready) begin
        step();
        break;
      end
      waited++;
      if (waited > 200) begin
        n_checks++;
        $display("FAIL byte_accept: byte %h not taken after %0d cycles, required acceptance", b, waited);
        step();
        break;
      end
    end
    bus.i_byte_valid = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
  endtask

  task automatic send_stream();
    step();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  task automatic drain();
    int k = 0;
    ready_mode = 0;
    step();
    while (bus.o_word_valid && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      $display("FAIL drain: o_word_valid still 1 after %0d cycles, required 0", k);
    end
    repeat (3) step();
  endtask

  task automatic mark();
    b_words = obs_q.size();
    b_sync  = obs_sync;
    b_done  = obs_done;
    b_csum  = obs_csum;
  endtask

  // Appends one frame; payload is either a stepped sequence or random bytes.
  task automatic add_frame(input logic [15:0] addr, input int nw, input logic [7:0] first,
                           input logic [7:0] step_b, input bit rnd, input bit bad);
    logic [7:0] sum, b, nxt;
    stim.push_back(8'hA5);
    stim.push_back(addr[15:8]);
    stim.push_back(addr[7:0]);
    stim.push_back(8'(nw));
    sum = 8'(addr[15:8] + addr[7:0] + 8'(nw));
    nxt = first;
    for (int k = 0; k < nw * BPW; k++) begin
      b   = rnd ? 8'($urandom) : nxt;
      nxt = 8'(nxt + step_b);
      stim.push_back(b);
      sum = 8'(sum + b);
    end
`ifdef CHECKSUM_EN
    stim.push_back(8'(8'(8'h00 - sum) + {7'd0, bad}));
`else
    if (bad) sum = 8'h00;
`endif
  endtask

  // Reference: walk the byte list as frames, little-endian byte packing, address per word.
  task automatic run_model();
    int i = 0;
    int n;
    logic [15:0] a;
    logic [7:0]  sum;
    wrec_t       r;
    exp_q.delete();
    exp_sync = 0;
    exp_done = 0;
    exp_csum = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        exp_sync++;
        i++;
      end else begin
        a   = {stim[i+1], stim[i+2]};
        n   = int'(stim[i+3]);
        sum = 8'(stim[i+1] + stim[i+2] + stim[i+3]);
        i  += 4;
        for (int w = 0; w < n; w++) begin
          r.word = '0;
          for (int k = 0; k < BPW; k++) begin
            r.word[k*8 +: 8] = stim[i];
            sum = 8'(sum + stim[i]);
            i++;
          end
          r.addr = 16'(a + 16'(w));
          r.last = (w == n - 1);
          exp_q.push_back(r);
        end
`ifdef CHECKSUM_EN
        if (8'(sum + stim[i]) != 8'h00) exp_csum++;
        i++;
`endif
        exp_done++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({bus.o_byte_ready, bus.o_word_valid, bus.o_last, bus.o_frame_done, bus.o_sync_err,
         bus.o_csum_err} !== 6'b100000)
      $display("FAIL reset_flags: got rdy/val/last/done/sync/csum=%b, want 100000",
               {bus.o_byte_ready, bus.o_word_valid, bus.o_last, bus.o_frame_done,
                bus.o_sync_err, bus.o_csum_err});
    else n_pass++;
    n_checks++;
    if (bus.o_word !== '0) $display("FAIL reset_word: got %h, want 0", bus.o_word);
    else n_pass++;
    n_checks++;
    if (bus.o_addr !== 16'h0) $display("FAIL reset_addr: got %h, want 0", bus.o_addr);
    else n_pass++;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    wrec_t got;
    stim.delete();
    add_frame(16'h1234, 2, 8'h01, 8'h01, 1'b0, 1'b0);
    run_model();
    mark();
    send_stream();
    drain();
    n_checks++;
    if (obs_q.size() - b_words !== exp_q.size())
      $display("FAIL basic_count: got %0d words, want %0d", obs_q.size() - b_words, exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (b_words + i < obs_q.size()) ? obs_q[b_words + i] : '0;
      n_checks++;
      if (got !== exp_q[i])
        $display("FAIL basic_word[%0d]: got %h@%h last=%b, want %h@%h last=%b", i,
                 got.word, got.addr, got.last, exp_q[i].word, exp_q[i].addr, exp_q[i].last);
      else n_pass++;
    end
    got = (b_words < obs_q.size()) ? obs_q[b_words] : '0;
    n_checks++;
    if ({got.word, got.addr} !== {32'h04030201, 16'h1234})
      $display("FAIL basic_first: got %h@%h, want 04030201@1234", got.word, got.addr);
    else n_pass++;
    n_checks++;
    if ({obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum} !== {exp_sync, exp_done, exp_csum})
      $display("FAIL basic_pulses: got sync/done/csum=%0d/%0d/%0d, want %0d/%0d/%0d",
               obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum, exp_sync, exp_done, exp_csum);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    wrec_t got;
    logic [W_DATA-1:0] w0;
    logic [15:0] a0;
    stim.delete();
    add_frame(16'h1234, 2, 8'h01, 8'h01, 1'b0, 1'b0);
    run_model();
    mark();
    ready_mode = 2;
    step();
    step();
    fork
      send_stream();
      begin
        int k = 0;
        while (k < 200) begin
          @(negedge i_clk);
          if (bus.o_word_valid) break;
          k++;
        end
        w0 = bus.o_word;
        a0 = bus.o_addr;
        repeat (5) begin
          @(negedge i_clk);
          n_checks++;
          if (bus.o_byte_ready !== 1'b0)
            $display("FAIL bp_ready: got o_byte_ready=%b, want 0", bus.o_byte_ready);
          else n_pass++;
          n_checks++;
          if ({bus.o_word_valid, bus.o_word, bus.o_addr} !== {1'b1, w0, a0} || k >= 200)
            $display("FAIL bp_hold: got v=%b %h@%h, want v=1 %h@%h", bus.o_word_valid,
                     bus.o_word, bus.o_addr, w0, a0);
          else n_pass++;
        end
        ready_mode = 0;
      end
    join
    drain();
    n_checks++;
    if (obs_q.size() - b_words !== exp_q.size())
      $display("FAIL bp_count: got %0d words, want %0d", obs_q.size() - b_words, exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (b_words + i < obs_q.size()) ? obs_q[b_words + i] : '0;
      n_checks++;
      if (got !== exp_q[i])
        $display("FAIL bp_word[%0d]: got %h@%h last=%b, want %h@%h last=%b", i,
                 got.word, got.addr, got.last, exp_q[i].word, exp_q[i].addr, exp_q[i].last);
      else n_pass++;
    end
  endtask

  task automatic test_sync_hunt();
    wrec_t got;
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'hFF);
    add_frame(16'hFFFF, 1, 8'h11, 8'h11, 1'b0, 1'b0);
    run_model();
    mark();
    gap_max = 1;
    send_stream();
    drain();
    gap_max = 0;
    n_checks++;
    if (obs_q.size() - b_words !== exp_q.size())
      $display("FAIL sync_count: got %0d words, want %0d", obs_q.size() - b_words, exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (b_words + i < obs_q.size()) ? obs_q[b_words + i] : '0;
      n_checks++;
      if (got !== exp_q[i])
        $display("FAIL sync_word[%0d]: got %h@%h last=%b, want %h@%h last=%b", i,
                 got.word, got.addr, got.last, exp_q[i].word, exp_q[i].addr, exp_q[i].last);
      else n_pass++;
    end
    n_checks++;
    if ({obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum} !== {exp_sync, exp_done, exp_csum})
      $display("FAIL sync_pulses: got sync/done/csum=%0d/%0d/%0d, want %0d/%0d/%0d",
               obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum, exp_sync, exp_done, exp_csum);
    else n_pass++;
  endtask

  task automatic test_empty();
    stim.delete();
    add_frame(16'h0010, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_model();
    mark();
    send_stream();
    drain();
    n_checks++;
    if (obs_q.size() - b_words !== 0)
      $display("FAIL empty_count: got %0d words, want 0", obs_q.size() - b_words);
    else n_pass++;
    n_checks++;
    if ({obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum} !== {exp_sync, exp_done, exp_csum})
      $display("FAIL empty_pulses: got sync/done/csum=%0d/%0d/%0d, want %0d/%0d/%0d",
               obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum, exp_sync, exp_done, exp_csum);
    else n_pass++;
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    wrec_t got;
    stim.delete();
    add_frame(16'h1234, 2, 8'h01, 8'h01, 1'b0, 1'b0);
    add_frame(16'h1234, 2, 8'h01, 8'h01, 1'b0, 1'b1);
    run_model();
    mark();
    send_stream();
    drain();
    n_checks++;
    if (obs_q.size() - b_words !== exp_q.size())
      $display("FAIL csum_count: got %0d words, want %0d", obs_q.size() - b_words, exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (b_words + i < obs_q.size()) ? obs_q[b_words + i] : '0;
      n_checks++;
      if (got !== exp_q[i])
        $display("FAIL csum_word[%0d]: got %h@%h last=%b, want %h@%h last=%b", i,
                 got.word, got.addr, got.last, exp_q[i].word, exp_q[i].addr, exp_q[i].last);
      else n_pass++;
    end
    n_checks++;
    if ({obs_done - b_done, obs_csum - b_csum} !== {32'd2, 32'd1})
      $display("FAIL csum_pulses: got done/csum=%0d/%0d, want 2/1",
               obs_done - b_done, obs_csum - b_csum);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    wrec_t got;
    stim.delete();
    add_frame(16'h1234, 2, 8'h01, 8'h01, 1'b0, 1'b0);
    stim = stim[0:7];
    mark();
    ready_mode = 2;
    step();
    step();
    send_stream();
    @(negedge i_clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_word_valid, bus.o_byte_ready, bus.o_frame_done} !== 3'b010)
      $display("FAIL rstmid_outputs: got valid/ready/done=%b, want 010",
               {bus.o_word_valid, bus.o_byte_ready, bus.o_frame_done});
    else n_pass++;
    step();
    resetn = 1'b1;
    ready_mode = 0;
    n_checks++;
    if ({obs_q.size() - b_words, obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum} !== 128'd0)
      $display("FAIL rstmid_partial: got words/sync/done/csum=%0d/%0d/%0d/%0d, want 0/0/0/0",
               obs_q.size() - b_words, obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum);
    else n_pass++;
    stim.delete();
    add_frame(16'h1234, 2, 8'h01, 8'h01, 1'b0, 1'b0);
    run_model();
    mark();
    send_stream();
    drain();
    n_checks++;
    if (obs_q.size() - b_words !== exp_q.size())
      $display("FAIL rstmid_count: got %0d words, want %0d", obs_q.size() - b_words, exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (b_words + i < obs_q.size()) ? obs_q[b_words + i] : '0;
      n_checks++;
      if (got !== exp_q[i])
        $display("FAIL rstmid_word[%0d]: got %h@%h last=%b, want %h@%h last=%b", i,
                 got.word, got.addr, got.last, exp_q[i].word, exp_q[i].addr, exp_q[i].last);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    wrec_t got;
    logic [7:0] b;
    stim.delete();
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      add_frame((f == 0) ? 16'hFFFE : 16'($urandom), (f == 0) ? 3 : int'($urandom_range(0, 5)),
                8'h00, 8'h00, 1'b1, ($urandom_range(0, 3) == 0));
    end
    run_model();
    mark();
    gap_max    = 2;
    ready_mode = 1;
    send_stream();
    drain();
    gap_max = 0;
    n_checks++;
    if (obs_q.size() - b_words !== exp_q.size())
      $display("FAIL rand_count: got %0d words, want %0d", obs_q.size() - b_words, exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (b_words + i < obs_q.size()) ? obs_q[b_words + i] : '0;
      n_checks++;
      if (got !== exp_q[i])
        $display("FAIL rand_word[%0d]: got %h@%h last=%b, want %h@%h last=%b", i,
                 got.word, got.addr, got.last, exp_q[i].word, exp_q[i].addr, exp_q[i].last);
      else n_pass++;
    end
    n_checks++;
    if ({obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum} !== {exp_sync, exp_done, exp_csum})
      $display("FAIL rand_pulses: got sync/done/csum=%0d/%0d/%0d, want %0d/%0d/%0d",
               obs_sync - b_sync, obs_done - b_done, obs_csum - b_csum, exp_sync, exp_done, exp_csum);
    else n_pass++;
  endtask

  initial begin
    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_sync_hunt();
    test_empty();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
